// File: rtl/vx_scalar_scoreboard.sv
// vx_scalar_scoreboard: per-warp register scoreboard for one issue slot.
// It holds each instruction until none of its source registers, or its
// destination register, has a write outstanding. It then passes the
// instruction into a one-entry registered output stage with a valid/ready
// handshake.
// Optional feature macro: VX_SCOREBOARD_BYPASS_EN. When it is defined, a
// writeback end-of-packet clears the hazard in the same cycle. When it is
// undefined, the hazard check sees only the registered busy state.

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 1
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module vx_scalar_scoreboard #(
    parameter int WARP_CNT    = `NUM_WARPS,
    parameter int ISSUE_CNT   = `ISSUE_WIDTH,
    parameter int ISSUE_WIS_W = `LOG2UP(`NUM_WARPS / `ISSUE_WIDTH),
    parameter int DATA_W      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    // instruction buffer side
    input  logic                   ibuf_valid,
    input  logic [ISSUE_WIS_W-1:0] ibuf_wis,
    input  logic                   ibuf_wb,
    input  logic [`NR_BITS-1:0]    ibuf_rd,
    input  logic [`NR_BITS-1:0]    ibuf_rs1,
    input  logic [`NR_BITS-1:0]    ibuf_rs2,
    input  logic [`NR_BITS-1:0]    ibuf_rs3,
    input  logic [DATA_W-1:0]      ibuf_data,
    output logic                   ibuf_ready,
    // operand fetch side
    output logic                   out_valid,
    output logic [ISSUE_WIS_W-1:0] out_wis,
    output logic                   out_wb,
    output logic [`NR_BITS-1:0]    out_rd,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    // writeback side
    input  logic                   wb_valid,
    input  logic [ISSUE_WIS_W-1:0] wb_wis,
    input  logic [`NR_BITS-1:0]    wb_rd,
    input  logic                   wb_eop,
    // performance counter
    output logic [31:0]            perf_stalls
);

    localparam int WPS      = WARP_CNT / ISSUE_CNT;
    localparam int NUM_REGS = 1 << `NR_BITS;

    // Busy bits, one row per warp in the slot.
    logic [NUM_REGS-1:0]    busy_q [WPS];
    logic [NUM_REGS-1:0]    busy_d [WPS];

    // Output stage registers.
    logic                   out_valid_q, out_valid_d;
    logic [ISSUE_WIS_W-1:0] out_wis_q,   out_wis_d;
    logic                   out_wb_q,    out_wb_d;
    logic [`NR_BITS-1:0]    out_rd_q,    out_rd_d;
    logic [DATA_W-1:0]      out_data_q,  out_data_d;
    logic [31:0]            stalls_q,    stalls_d;

    logic                   clr_en;
    logic                   accept;
    logic                   set_en;
    logic                   hazard;
    logic [NUM_REGS-1:0]    warp_busy;

    // A writeback releases its register only on the last beat.
    assign clr_en = wb_valid & wb_eop;

    // Select the busy row of the requesting warp. With the bypass enabled,
    // a same-cycle eop clear of that warp hides the bit from the check.
    always_comb begin
        warp_busy = '0;
        for (int w = 0; w < WPS; w++) begin
            if (ibuf_wis == ISSUE_WIS_W'(w)) begin
                warp_busy = busy_q[w];
            end
        end
`ifdef VX_SCOREBOARD_BYPASS_EN
        if (clr_en && (wb_wis == ibuf_wis)) begin
            warp_busy[wb_rd] = 1'b0;
        end
`endif
    end

    // Hazard detection and the acceptance handshake. Ready does not depend
    // on ibuf_valid.
    always_comb begin
        hazard = warp_busy[ibuf_rs1] | warp_busy[ibuf_rs2] | warp_busy[ibuf_rs3]
               | (ibuf_wb & warp_busy[ibuf_rd]);
        ibuf_ready = ~hazard & (~out_valid_q | out_ready);
        accept     = ibuf_valid & ibuf_ready;
        // x0 is hardwired to zero and is never tracked.
        set_en     = accept & ibuf_wb & (ibuf_rd != '0);
    end

    // Compute the next busy state. The set is applied after the clear so
    // that a set wins when both hit the same bit.
    always_comb begin
        for (int w = 0; w < WPS; w++) begin
            busy_d[w] = busy_q[w];
            if (clr_en && (wb_wis == ISSUE_WIS_W'(w))) begin
                busy_d[w][wb_rd] = 1'b0;
            end
            if (set_en && (ibuf_wis == ISSUE_WIS_W'(w))) begin
                busy_d[w][ibuf_rd] = 1'b1;
            end
        end
    end

    // Compute the next output stage and the saturating stall counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_wis_d   = out_wis_q;
        out_wb_d    = out_wb_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        stalls_d    = stalls_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_wis_d   = ibuf_wis;
            out_wb_d    = ibuf_wb;
            out_rd_d    = ibuf_rd;
            out_data_d  = ibuf_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (ibuf_valid && hazard && (stalls_q != 32'hFFFF_FFFF)) begin
            stalls_d = stalls_q + 32'd1;
        end
    end

    // State registers. Reset drops the in-flight entry and all busy bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WPS; w++) begin
                busy_q[w] <= '0;
            end
            out_valid_q <= 1'b0;
            out_wis_q   <= '0;
            out_wb_q    <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            stalls_q    <= '0;
        end else begin
            for (int w = 0; w < WPS; w++) begin
                busy_q[w] <= busy_d[w];
            end
            out_valid_q <= out_valid_d;
            out_wis_q   <= out_wis_d;
            out_wb_q    <= out_wb_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            stalls_q    <= stalls_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_wis     = out_wis_q;
    assign out_wb      = out_wb_q;
    assign out_rd      = out_rd_q;
    assign out_data    = out_data_q;
    assign perf_stalls = stalls_q;

endmodule

// File: tb/tb_vx_scalar_scoreboard.sv
// Testbench for vx_scalar_scoreboard with the default configuration:
// 4 warps per slot, 32 registers, and a 1-bit payload.
// It runs a cycle-by-cycle vector table, then hand-written sequences for
// output back-pressure and for reset in the middle of operation.

`ifndef NR_BITS
`define NR_BITS 5
`endif

module tb_vx_scalar_scoreboard;

    localparam int WISW = 2;
    localparam int NRB  = `NR_BITS;

`ifdef VX_SCOREBOARD_BYPASS_EN
    localparam int S = 2;   // stall count after the dependency sequence
`else
    localparam int S = 3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             ibuf_valid;
    logic [WISW-1:0]  ibuf_wis;
    logic             ibuf_wb;
    logic [NRB-1:0]   ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
    logic [0:0]       ibuf_data;
    logic             ibuf_ready;
    logic             out_valid;
    logic [WISW-1:0]  out_wis;
    logic             out_wb;
    logic [NRB-1:0]   out_rd;
    logic [0:0]       out_data;
    logic             out_ready;
    logic             wb_valid;
    logic [WISW-1:0]  wb_wis;
    logic [NRB-1:0]   wb_rd;
    logic             wb_eop;
    logic [31:0]      perf_stalls;

    vx_scalar_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .ibuf_valid  (ibuf_valid),
        .ibuf_wis    (ibuf_wis),
        .ibuf_wb     (ibuf_wb),
        .ibuf_rd     (ibuf_rd),
        .ibuf_rs1    (ibuf_rs1),
        .ibuf_rs2    (ibuf_rs2),
        .ibuf_rs3    (ibuf_rs3),
        .ibuf_data   (ibuf_data),
        .ibuf_ready  (ibuf_ready),
        .out_valid   (out_valid),
        .out_wis     (out_wis),
        .out_wb      (out_wb),
        .out_rd      (out_rd),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .wb_valid    (wb_valid),
        .wb_wis      (wb_wis),
        .wb_rd       (wb_rd),
        .wb_eop      (wb_eop),
        .perf_stalls (perf_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        int         wis;
        logic       wb;
        int         rd, rs1, rs2, rs3;
        logic       ordy;
        logic       wbv;
        int         wbwis, wbrd;
        logic       eop;
        logic       exp_ready;   // ibuf_ready before the edge
        logic       exp_ov;      // out_valid after the edge
        int         exp_rd;      // out_rd after the edge, checked when exp_ov
        int         exp_stalls;  // perf_stalls after the edge
    } vec_t;

    vec_t vecs [14];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic v, int wis, logic wb, int rd, int rs1, int rs2, int rs3,
                                logic ordy, logic wbv, int wbwis, int wbrd, logic eop,
                                logic er, logic eov, int erd, int est);
        vec_t r;
        r.v = v; r.wis = wis; r.wb = wb; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.rs3 = rs3;
        r.ordy = ordy; r.wbv = wbv; r.wbwis = wbwis; r.wbrd = wbrd; r.eop = eop;
        r.exp_ready = er; r.exp_ov = eov; r.exp_rd = erd; r.exp_stalls = est;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic drive_ibuf(input logic v, input int wis, input logic wb, input int rd,
                              input int rs1, input int rs2, input int rs3, input logic d);
        ibuf_valid = v;
        ibuf_wis   = WISW'(wis);
        ibuf_wb    = wb;
        ibuf_rd    = NRB'(rd);
        ibuf_rs1   = NRB'(rs1);
        ibuf_rs2   = NRB'(rs2);
        ibuf_rs3   = NRB'(rs3);
        ibuf_data  = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle script. Each row is one clock cycle.
        //            v  wis wb rd rs1 rs2 rs3 ordy wbv wwis wrd eop  rdy ov rd  stalls
        vecs[0]  = mk(1, 0, 1, 5, 1, 0, 0, 1, 0, 0, 0, 0,   1, 1, 5, 0);
        vecs[1]  = mk(1, 0, 1, 6, 2, 0, 0, 1, 0, 0, 0, 0,   1, 1, 6, 0);
        vecs[2]  = mk(1, 1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 7, 0);   // A
        vecs[3]  = mk(1, 1, 0, 3, 0, 7, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1);   // B stalls
        vecs[4]  = mk(1, 1, 0, 3, 0, 7, 0, 1, 1, 1, 7, 0,   0, 0, 0, 2);   // non-eop beat
`ifdef VX_SCOREBOARD_BYPASS_EN
        vecs[5]  = mk(1, 1, 0, 3, 0, 7, 0, 1, 1, 1, 7, 1,   1, 1, 3, 2);   // eop: bypass
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 2);
`else
        vecs[5]  = mk(1, 1, 0, 3, 0, 7, 0, 1, 1, 1, 7, 1,   0, 0, 0, 3);   // eop cycle N
        vecs[6]  = mk(1, 1, 0, 3, 0, 7, 0, 1, 0, 0, 0, 0,   1, 1, 3, 3);   // N+1
`endif
        vecs[7]  = mk(1, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 7, S);   // w0 writes 7
        vecs[8]  = mk(1, 1, 0, 4, 7, 0, 0, 1, 0, 0, 0, 0,   1, 1, 4, S);   // w1 reads 7
        vecs[9]  = mk(1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, S);   // wb to x0
        vecs[10] = mk(1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, S);   // x0 again
        vecs[11] = mk(1, 2, 1, 9, 0, 0, 0, 1, 1, 2, 9, 1,   1, 1, 9, S);   // set+clr
        vecs[12] = mk(1, 2, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0,   0, 0, 0, S+1);
        vecs[13] = mk(1, 2, 0, 1, 0, 0, 9, 0, 0, 0, 0, 0,   0, 0, 0, S+2);

        drive_ibuf(0, 0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        wb_valid = 1'b0; wb_wis = '0; wb_rd = '0; wb_eop = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_wis",   32'(out_wis), 0);
        chk("reset out_wb",    32'(out_wb), 0);
        chk("reset out_rd",    32'(out_rd), 0);
        chk("reset out_data",  32'(out_data), 0);
        chk("reset perf",      perf_stalls, 0);
        chk("reset ibuf_ready", 32'(ibuf_ready), 1);

        for (int i = 0; i < 14; i++) begin
            drive_ibuf(vecs[i].v, vecs[i].wis, vecs[i].wb, vecs[i].rd,
                       vecs[i].rs1, vecs[i].rs2, vecs[i].rs3, 1'b0);
            out_ready = vecs[i].ordy;
            wb_valid  = vecs[i].wbv;
            wb_wis    = WISW'(vecs[i].wbwis);
            wb_rd     = NRB'(vecs[i].wbrd);
            wb_eop    = vecs[i].eop;
            #1;
            chk($sformatf("vec%0d ibuf_ready", i), 32'(ibuf_ready), 32'(vecs[i].exp_ready));
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                chk($sformatf("vec%0d out_rd", i), 32'(out_rd), 32'(vecs[i].exp_rd));
            end
            chk($sformatf("vec%0d perf", i), perf_stalls, 32'(vecs[i].exp_stalls));
        end
        wb_valid = 1'b0; wb_eop = 1'b0;

        // Back-pressure: hold one entry with out_ready low for 4 cycles.
        out_ready = 1'b0;
        drive_ibuf(1, 3, 0, 10, 0, 0, 0, 1'b1);
        #1;
        chk("hold load ready", 32'(ibuf_ready), 1);
        step();
        drive_ibuf(1, 3, 0, 11, 0, 0, 0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("hold%0d ibuf_ready", c), 32'(ibuf_ready), 0);
            chk($sformatf("hold%0d out", c), {out_valid, out_wis, out_rd, out_data},
                {1'b1, 2'd3, 5'd10, 1'b1});
            step();
        end
        chk("hold perf", perf_stalls, 32'(S+2));
        out_ready = 1'b1;
        #1;
        chk("release ibuf_ready", 32'(ibuf_ready), 1);
        step();
        chk("release out", {out_valid, out_wis, out_rd, out_data}, {1'b1, 2'd3, 5'd11, 1'b0});
        drive_ibuf(0, 0, 0, 0, 0, 0, 0, 1'b0);
        step();
        chk("drain out_valid", 32'(out_valid), 0);

        // Reset while busy bits are set: warp 2 rd9 and warp 0 rd5 are pending.
        drive_ibuf(0, 2, 0, 0, 9, 0, 0, 1'b0);
        #1;
        chk("pre-reset w2 rs1=9 ready", 32'(ibuf_ready), 0);
        drive_ibuf(1, 0, 0, 12, 5, 0, 0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_ibuf(0, 0, 0, 0, 0, 0, 0, 1'b0);
        #1;
        chk("post-reset out_valid", 32'(out_valid), 0);
        chk("post-reset perf", perf_stalls, 0);
        drive_ibuf(1, 2, 0, 0, 9, 0, 0, 1'b0);
        #1;
        chk("post-reset w2 rs1=9 ready", 32'(ibuf_ready), 1);
        drive_ibuf(1, 0, 0, 0, 5, 6, 0, 1'b0);
        #1;
        chk("post-reset w0 rs5/6 ready", 32'(ibuf_ready), 1);
        drive_ibuf(0, 0, 0, 0, 0, 0, 0, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
